ram_master: RTL and testbench
=============================

RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameters: ADDR_W, default 16, RAM address width; DATA_W, default 8, RAM data width; LEN_W, default 8, burst-length field width.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 cmd_valid  input  1  command offered. cmd_ready  output  1  command accepted when both are high.
REQ-005 cmd_we  input  1  1 = write burst, 0 = read burst. cmd_addr  input  ADDR_W  start address. cmd_len  input  LEN_W  beats minus one.
REQ-006 wd_valid  input  1; wd_ready  output  1; wd_data  input  DATA_W  write-data stream, one beat per handshake.
REQ-007 rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  DATA_W  read-data stream.
REQ-008 busy  output  1  high while a burst is in progress.
REQ-009 ram_we  output  1; ram_wrdata  output  DATA_W; ram_wradd  output  ADDR_W; ram_rdadd  output  ADDR_W  drive the RAM ports.
REQ-010 ram_rddata  input  DATA_W  RAM read data, registered in the RAM, valid one clk after ram_rdadd is sampled.

Function
REQ-011 FSM states: IDLE, WRITE, READ, DRAIN; cmd_ready is high only in IDLE.
REQ-012 IDLE: on cmd handshake, latch addr, remaining count = cmd_len+1, and go to WRITE if cmd_we=1, else READ.
REQ-013 WRITE: wd_ready=1; on each wd handshake, ram_we=1 in that cycle with ram_wradd=current addr and ram_wrdata=wd_data; addr+1 and count-1.
REQ-014 ram_we SHALL be 0 in every cycle without a wd handshake; the last beat returns to IDLE on the next edge.
REQ-015 READ: issue one ram_rdadd per cycle while the skid buffer has space for the in-flight beat; addr+1 and count-1 per issue.
REQ-016 After the last read issue, go to DRAIN; DRAIN returns to IDLE once the skid buffer is empty and no read is in flight.
REQ-017 Read data captured one cycle after issue enters a 2-entry skid buffer; rsp_valid = buffer non-empty; pop on rsp_valid && rsp_ready.
REQ-018 Read data SHALL be delivered in address order with no loss or duplication under any rsp_ready pattern.
REQ-019 Full throughput: with rsp_ready held high, one rsp beat per cycle; first rsp_valid 2 cycles after the cmd handshake.
REQ-020 Address arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 16'h0000 within a burst.
REQ-021 cmd_len=0 gives exactly one beat; cmd_len=all-ones gives 2^LEN_W beats.
REQ-022 busy = (state != IDLE).
REQ-023 ram_rdadd holds its last value when not issuing; out-of-burst RAM reads are harmless and are discarded.
REQ-024 wd_valid while not in WRITE is ignored (wd_ready=0).

Reset
REQ-025 While rst is high: state=IDLE, cmd_ready=1, wd_ready=0, rsp_valid=0, busy=0, ram_we=0, ram_wradd=0, ram_rdadd=0, ram_wrdata=0, rsp_data=0, skid buffer empty, count=0.
REQ-026 Reset mid-burst aborts the burst immediately; no RAM write occurs after rst is asserted, and in-flight read data is discarded.

Structure
REQ-027 Package ram_master_pkg holds the FSM state enum and default width constants ADDR_W, DATA_W and LEN_W.
REQ-028 The skid buffer is sub-module ram_master_skid (2-entry, valid/ready both sides); the remaining logic is flat.

Verification
REQ-029 Write burst addr=1, len=2, data A3,8F,BD with wd_valid always high -> ram_we high for 3 consecutive cycles at addrs 1,2,3; then read addr=1, len=2 -> rsp A3,8F,BD.
REQ-030 Wrap: write addr=FFFE, len=3, data 11,22,33,44 -> writes at FFFE, FFFF, 0000, 0001; a read-back returns the same order.
REQ-031 Backpressure: read of 8 beats with rsp_ready toggling 1,0,0,1 repeatedly -> all 8 beats in order, none lost or duplicated, and rsp_data stable while rsp_valid && !rsp_ready.
REQ-032 Gapped write data: wd_valid low for 3 cycles mid-burst -> ram_we low in exactly those cycles, and the address does not advance.
REQ-033 Reset mid-read after 2 of 5 rsp beats -> the next cycle has rsp_valid=0 and busy=0, and a new command is accepted with correct data.
REQ-034 Single beat len=0 at addr FFFF writing FF, then read -> exactly one rsp beat FF, with cmd_ready returning high the cycle after.

Source files
------------

// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - shared widths and FSM state type for the burst RAM master
package ram_master_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
endpackage

// File: rtl/ram_master_skid.sv
// rtl/ram_master_skid.sv - 2-entry skid buffer catching registered RAM read data
module ram_master_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  logic [1:0]        level;
  logic [DATA_W-1:0] head, tail;
  logic              push, pop;

  assign in_ready  = (level != 2'd2);
  assign out_valid = (level != 2'd0);
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (level == 2'd0) head <= in_data;
          else               tail <= in_data;
          level <= level + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          level <= level - 2'd1;
        end
        2'b11: begin
          // Level is unchanged; the new beat lands behind whatever remains.
          if (level == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ram_master.sv
// rtl/ram_master.sv - command-driven burst master for a RAM with registered read data
module ram_master #(
  parameter int ADDR_W = ram_master_pkg::ADDR_W,
  parameter int DATA_W = ram_master_pkg::DATA_W,
  parameter int LEN_W  = ram_master_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wrdata,
  output logic [ADDR_W-1:0] ram_wradd,
  output logic [ADDR_W-1:0] ram_rdadd,
  input  logic [DATA_W-1:0] ram_rddata
);
  import ram_master_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] addr, rdadd_q;
  logic [LEN_W:0]    count;
  logic              inflight;
  logic              skid_in_ready;
  logic              wd_hs, pop, issue;
  logic [2:0]        occ;

  ram_master_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_ready  (skid_in_ready),
    .in_data   (ram_rddata),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .out_data  (rsp_data)
  );

  assign wd_hs = wd_ready && wd_valid;
  assign pop   = rsp_valid && rsp_ready;

  // Beats the buffer will hold once this cycle settles; a new issue is only
  // safe if it still has a slot when it arrives one edge later.
  assign occ   = {1'b0, !skid_in_ready, skid_in_ready && rsp_valid}
               + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == READ) && (occ < 3'd2);

  assign ram_we     = wd_hs;
  assign ram_wradd  = addr;
  assign ram_wrdata = wd_hs ? wd_data : '0;
  assign ram_rdadd  = issue ? addr : rdadd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      rdadd_q   <= '0;
      inflight  <= 1'b0;
      cmd_ready <= 1'b1;
      wd_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) rdadd_q <= addr;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            count     <= {1'b0, cmd_len} + (LEN_W+1)'(1);
            state     <= cmd_we ? WRITE : READ;
            cmd_ready <= 1'b0;
            wd_ready  <= cmd_we;
            busy      <= 1'b1;
          end
        end
        WRITE: begin
          if (wd_hs) begin
            addr  <= addr + ADDR_W'(1);
            count <= count - (LEN_W+1)'(1);
            if (count == (LEN_W+1)'(1)) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              wd_ready  <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr  <= addr + ADDR_W'(1);
            count <= count - (LEN_W+1)'(1);
            if (count == (LEN_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as the final beat pops so a new command is taken next cycle.
          if (occ == 3'd0) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - scoreboard bench for ram_master with a behavioural RAM
module tb_ram_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [7:0]  wd_data;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_data;
  logic        busy, ram_we;
  logic [7:0]  ram_wrdata, ram_rddata;
  logic [15:0] ram_wradd, ram_rdadd;

  always #5 clk = ~clk;

  ram_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .ram_we(ram_we), .ram_wrdata(ram_wrdata),
    .ram_wradd(ram_wradd), .ram_rdadd(ram_rdadd), .ram_rddata(ram_rddata)
  );

  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wradd] <= ram_wrdata;
    ram_rddata <= mem[ram_rdadd];
  end

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef logic [7:0] bq_t[$];

  int         checks = 0;
  int         failures = 0;
  wr_t        wq[$];
  logic [7:0] rq[$];
  wr_t        wexp;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every RAM write and every accepted rsp beat to the queues.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ram_we) begin
        check("wr_expected", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          wexp = wq.pop_front();
          check("wr_addr", 32'(ram_wradd), 32'(wexp.a));
          check("wr_data", 32'(ram_wrdata), 32'(wexp.d));
        end
      end
      if (prev_stall) begin
        check("stall_valid", 32'(rsp_valid), 1);
        check("stall_data", 32'(rsp_data), 32'(prev_data));
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(rq.size() != 0), 1);
        if (rq.size() != 0) check("rsp_data", 32'(rsp_data), 32'(rq.pop_front()));
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_cmd(input logic we, input logic [15:0] a, input logic [7:0] len);
    int n = 0;
    cmd_we = we; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [15:0] a, input bq_t d, input int gap_after, input int gap_len);
    foreach (d[i]) wq.push_back({16'(a + 16'(i)), d[i]});
    send_cmd(1'b1, a, 8'(d.size() - 1));
    foreach (d[i]) begin
      wd_valid = 1'b1; wd_data = d[i];
      @(negedge clk);
      check("wd_ready_beat", 32'(wd_ready), 1);
      check("ram_we_beat", 32'(ram_we), 1);
      @(posedge clk); #1;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          wd_valid = 1'b0; wd_data = 8'h5A;
          @(negedge clk);
          check("ram_we_gap", 32'(ram_we), 0);
          check("addr_hold", 32'(ram_wradd), 32'(16'(a + 16'(i) + 16'd1)));
          @(posedge clk); #1;
        end
      end
    end
    wd_valid = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_write", 32'(cmd_ready), 1);
    check("busy_after_write", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic read_burst(input logic [15:0] a, input bq_t e, input logic [3:0] pat, input bit chk_lat);
    int n = 0, first_v = -1, first_hs = -1, last_hs = -1, beats = 0;
    bit done = 0;
    foreach (e[i]) rq.push_back(e[i]);
    send_cmd(1'b0, a, 8'(e.size() - 1));
    for (int i = 0; i < 300 && !done; i++) begin
      rsp_ready = pat[3 - (i % 4)];
      @(negedge clk); #1;
      n++;
      if (rsp_valid && first_v < 0) first_v = n;
      if (rsp_valid && rsp_ready) begin
        beats++;
        if (first_hs < 0) first_hs = n;
        last_hs = n;
        if (rq.size() == 0) done = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    check("read_done", 32'(done), 1);
    check("rsp_count", 32'(beats), 32'(e.size()));
    if (chk_lat) check("first_rsp_latency", 32'(first_v), 3);
    if (pat == 4'hF) check("throughput", 32'(last_hs - first_hs), 32'(e.size() - 1));
    @(negedge clk);
    check("cmd_ready_after_read", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t d;
    int  n;
    foreach (mem[i]) mem[i] = 8'h00;
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_len = 0;
    wd_valid = 0; wd_data = 0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_wd_ready", 32'(wd_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_wradd", 32'(ram_wradd), 0);
    check("rst_rdadd", 32'(ram_rdadd), 0);
    check("rst_wrdata", 32'(ram_wrdata), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    wd_valid = 1'b1; wd_data = 8'h77;
    @(negedge clk);
    check("idle_wd_ready", 32'(wd_ready), 0);
    check("idle_ram_we", 32'(ram_we), 0);
    @(posedge clk); #1;
    wd_valid = 1'b0;

    d.delete(); d.push_back(8'hA3); d.push_back(8'h8F); d.push_back(8'hBD);
    write_burst(16'h0001, d, -1, 0);
    read_burst(16'h0001, d, 4'hF, 1'b1);

    d.delete(); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33); d.push_back(8'h44);
    write_burst(16'hFFFE, d, -1, 0);
    read_burst(16'hFFFE, d, 4'hF, 1'b1);

    d.delete();
    for (int i = 0; i < 8; i++) d.push_back(8'(8'h90 + 8'(i * 7)));
    write_burst(16'h0040, d, -1, 0);
    read_burst(16'h0040, d, 4'b1001, 1'b0);

    d.delete(); d.push_back(8'hC1); d.push_back(8'hC2); d.push_back(8'hC3); d.push_back(8'hC4);
    write_burst(16'h0100, d, 1, 3);
    read_burst(16'h0100, d, 4'hF, 1'b1);

    d.delete();
    for (int i = 1; i <= 5; i++) d.push_back(8'(i));
    write_burst(16'h0200, d, -1, 0);
    foreach (d[i]) rq.push_back(d[i]);
    send_cmd(1'b0, 16'h0200, 8'd4);
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk); #1;
    while (rq.size() > 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("two_beats_before_reset", 32'(rq.size()), 3);
    rst = 1'b1;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_cmd_ready", 32'(cmd_ready), 1);
    check("reset_ram_we", 32'(ram_we), 0);
    rq.delete();
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b0;
    read_burst(16'h0200, d, 4'hF, 1'b1);

    d.delete(); d.push_back(8'hFF);
    write_burst(16'hFFFF, d, -1, 0);
    read_burst(16'hFFFF, d, 4'hF, 1'b1);

    repeat (3) @(negedge clk);
    check("wq_drained", 32'(wq.size()), 0);
    check("rq_drained", 32'(rq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
